master_interface: RTL
=====================

// Module: master_interface
// PURPOSE
//  Bus-side master port; turns a parallel user request (read/write one byte) into the serial bus protocol the
//  slave interfaces decode. Arbitrates via bus_request/bus_grant, shifts start bit + 15-bit address, then
//  shifts write data out or read data in. Handles OK/BUSY/DONE responses, split resume and timeouts.
// PARAMETERS
//  RESP_TIMEOUT   4    max consecutive NAK samples while awaiting OK or DONE before err
//  SPLIT_TIMEOUT  64   max cycles in SPLIT_WAIT before err
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   user request strobe; accepted only when req_ready=1
//  req_ready    out  1   1 in IDLE only
//  req_write    in   1   1=write, 0=read
//  req_slave    in   2   target slave address
//  req_mem_addr in   12  target RAM address
//  req_wdata    in   8   write byte
//  rd_data      out  8   read byte; valid with done on a read, held until the next read completes
//  done         out  1   1-cycle pulse: transaction completed with DONE
//  err          out  1   1-cycle pulse: aborted (timeout or grant lost)
//  bus_request  out  1   request to arbiter
//  bus_grant    in   1   arbiter grant to this master
//  master_en    out  1   enable for this master's tri-state drivers
//  addr         out  1   serial address line
//  w_data       out  1   serial write-data line
//  r_data       in   1   serial read-data line
//  response     in   2   slave response: 00 NAK, 01 BUSY, 10 OK, 11 DONE
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE, req_ready=1, all other outputs 0, rd_data=0.
//  addr/w_data are 0 whenever master_en=0. Reset mid-transaction -> IDLE immediately, no done/err.
//  Request latched (write, slave, mem_addr, wdata) on the edge req_valid&req_ready; frame = {slave,write,mem_addr}, 15 bits.
//  States:
//   IDLE: on accept -> REQ; bus_request<=1.
//   REQ: wait for bus_grant=1; on that edge master_en<=1, addr<=1 (start bit) -> SEND_ADDR.
//   SEND_ADDR: drive frame[14] down to frame[0], one bit per edge (15 edges); after frame[0] is driven -> WAIT_RESP, addr<=0.
//   WAIT_RESP: sample response each edge. OK: write -> SEND_DATA with w_data<=wdata[7] on the same edge;
//     read -> RECV_DATA. BUSY -> SPLIT_WAIT (bus_request<=0, master_en<=0). NAK: count, RESP_TIMEOUT-th NAK -> ERR.
//     DONE here is treated as NAK.
//   SEND_DATA: drive wdata[6..0] on next 7 edges; then w_data<=0 -> WAIT_DONE.
//   RECV_DATA: sample r_data on next 8 edges into shift reg, MSB first -> WAIT_DONE.
//   WAIT_DONE: DONE -> rd_data<=shift reg (read only), done<=1 -> IDLE. NAK counted as in WAIT_RESP -> ERR.
//   SPLIT_WAIT: master_en follows bus_grant. Sampling bus_grant=1 & response=OK resumes exactly as OK in WAIT_RESP.
//     SPLIT_TIMEOUT cycles elapsed -> ERR. No new start bit is sent on resume.
//   ERR: err<=1 -> IDLE.
//  Leaving to IDLE: bus_request<=0, master_en<=0, req_ready<=1.
//  Timing (E0 = edge driving start bit, write): addr bits on E1..E15; OK sampled E17; data bits driven E17..E24; DONE sampled E27.
//  Timing (read): OK sampled E17; r_data sampled E18..E25; DONE sampled E26.
//  Grant loss: bus_grant=0 sampled in SEND_ADDR, WAIT_RESP, SEND_DATA, RECV_DATA or WAIT_DONE -> ERR.
//  NAK counter clears on each state entry. req_valid while busy is ignored.
// TESTING
//  Write slave=1, mem_addr=0x0A5, wdata=0xC3 to idle slave -> addr stream 1,01,1,000010100101; w_data 11000011 MSB first; done at E27.
//  Read slave=2, mem_addr=0x010, RAM[0x010]=0x5A -> rd_data=0x5A, done pulse at E26, err=0.
//  Slave busy (5-cycle busy count) -> BUSY sampled, bus_request/master_en drop; on regrant + OK, transfer finishes, single done.
//  Request to slave=3 with no slave present -> 4 NAK samples after address -> err pulse, bus_request=0, req_ready=1.
//  Assert reset mid-SEND_DATA -> all outputs 0 asynchronously, req_ready=1; next write completes normally.
//  Back-to-back: read then write issued on the cycle req_ready returns -> two done pulses, no err.

Source files
------------

// File: rtl/master_interface.sv
// Serial bus master: turns a one-byte read/write request into the start-bit/address/data
// bus protocol, with grant arbitration, slave response handling, split resume and timeouts.
module master_interface #(
  parameter int RESP_TIMEOUT  = 4,
  parameter int SPLIT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_slave,
  input  logic [11:0] req_mem_addr,
  input  logic [7:0]  req_wdata,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic        master_en,
  output logic        addr,
  output logic        w_data,
  input  logic        r_data,
  input  logic [1:0]  response
);

  localparam logic [1:0] RSP_BUSY = 2'b01;
  localparam logic [1:0] RSP_OK   = 2'b10;
  localparam logic [1:0] RSP_DONE = 2'b11;

  localparam int NW = $clog2(RESP_TIMEOUT) + 1;
  localparam int SW = $clog2(SPLIT_TIMEOUT) + 1;

  typedef enum logic [3:0] {
    IDLE, REQ, SEND_ADDR, WAIT_RESP, SEND_DATA, RECV_DATA, WAIT_DONE, SPLIT_WAIT, ERR
  } state_t;

  state_t         state;
  logic           wr_q;
  logic [14:0]    frame_q;
  logic [7:0]     wdata_q;
  logic [7:0]     shift_q;
  logic [3:0]     bit_cnt;
  logic [NW-1:0]  nak_cnt;
  logic [SW-1:0]  split_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rd_data     <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
      bus_request <= 1'b0;
      master_en   <= 1'b0;
      addr        <= 1'b0;
      w_data      <= 1'b0;
      wr_q        <= 1'b0;
      frame_q     <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      nak_cnt     <= '0;
      split_cnt   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            frame_q     <= {req_slave, req_write, req_mem_addr};
            wdata_q     <= req_wdata;
            bus_request <= 1'b1;
            req_ready   <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus_grant) begin
            master_en <= 1'b1;
            addr      <= 1'b1;
            bit_cnt   <= '0;
            state     <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (!bus_grant) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            addr        <= 1'b0;
            state       <= ERR;
          end else if (bit_cnt != 4'd15) begin
            addr    <= frame_q[4'd14 - bit_cnt];
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            addr    <= 1'b0;
            nak_cnt <= '0;
            state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (!bus_grant) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            state       <= ERR;
          end else if (response == RSP_OK) begin
            bit_cnt <= '0;
            if (wr_q) begin
              w_data <= wdata_q[7];
              state  <= SEND_DATA;
            end else begin
              state  <= RECV_DATA;
            end
          end else if (response == RSP_BUSY) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            split_cnt   <= '0;
            state       <= SPLIT_WAIT;
          end else if (nak_cnt == NW'(RESP_TIMEOUT - 1)) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            state       <= ERR;
          end else begin
            nak_cnt <= nak_cnt + 1'b1;
          end
        end
        SEND_DATA: begin
          if (!bus_grant) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            w_data      <= 1'b0;
            state       <= ERR;
          end else if (bit_cnt != 4'd7) begin
            w_data  <= wdata_q[3'd6 - bit_cnt[2:0]];
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            w_data  <= 1'b0;
            nak_cnt <= '0;
            state   <= WAIT_DONE;
          end
        end
        RECV_DATA: begin
          if (!bus_grant) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            state       <= ERR;
          end else begin
            shift_q <= {shift_q[6:0], r_data};
            if (bit_cnt == 4'd7) begin
              nak_cnt <= '0;
              state   <= WAIT_DONE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus_grant) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            state       <= ERR;
          end else if (response == RSP_DONE) begin
            if (!wr_q) rd_data <= shift_q;
            done        <= 1'b1;
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end else if (nak_cnt == NW'(RESP_TIMEOUT - 1)) begin
            bus_request <= 1'b0;
            master_en   <= 1'b0;
            state       <= ERR;
          end else begin
            nak_cnt <= nak_cnt + 1'b1;
          end
        end
        SPLIT_WAIT: begin
          // Resume skips the address phase: the slave already holds our frame.
          master_en <= bus_grant;
          if (bus_grant && response == RSP_OK) begin
            bus_request <= 1'b1;
            bit_cnt     <= '0;
            if (wr_q) begin
              w_data <= wdata_q[7];
              state  <= SEND_DATA;
            end else begin
              state  <= RECV_DATA;
            end
          end else if (split_cnt == SW'(SPLIT_TIMEOUT - 1)) begin
            master_en <= 1'b0;
            state     <= ERR;
          end else begin
            split_cnt <= split_cnt + 1'b1;
          end
        end
        ERR: begin
          err         <= 1'b1;
          bus_request <= 1'b0;
          master_en   <= 1'b0;
          addr        <= 1'b0;
          w_data      <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          bus_request <= 1'b0;
          master_en   <= 1'b0;
          addr        <= 1'b0;
          w_data      <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
